// File: rtl/hmac_request_arbiter.sv
// hmac_request_arbiter: round-robin arbiter sharing one HMAC key-system port among NUM_REQ requesters
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   req_valid/req_word*/req_word_ready  per-requester job request and word stream
//   req_grant, req_done              one-hot grant held for the job, one-cycle completion pulse
//   keygen_start, key_valid          key generation request and key status
//   hmac_start, msg_*                job start pulse and granted message stream
//   hmac_done, hmac_value            key-system completion and result
//   hmac_result, busy, err_timeout   last good result, non-idle flag, timeout pulse
module hmac_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int KEYGEN_TIMEOUT = 50000,
  parameter int HMAC_TIMEOUT   = 200000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_word,
  input  logic [NUM_REQ-1:0]    req_word_valid,
  input  logic [NUM_REQ-1:0]    req_word_last,
  output logic [NUM_REQ-1:0]    req_word_ready,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [511:0]          hmac_result,
  output logic                  keygen_start,
  output logic                  hmac_start,
  input  logic                  key_valid,
  output logic [31:0]           msg_word,
  output logic                  msg_valid,
  output logic                  msg_last,
  input  logic                  msg_ready,
  input  logic                  hmac_done,
  input  logic [511:0]          hmac_value,
  output logic                  busy,
  output logic                  err_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, KEYGEN, START, STREAM, WAIT, DONE} state_t;
  state_t r_state;
  logic [IW-1:0] r_last, r_gidx, w_win, w_j;
  logic [NUM_REQ-1:0] r_grant, r_done;
  logic [511:0] r_result;
  logic [31:0] r_cnt;
  logic r_kstart, r_hstart, r_err, w_stream, w_xfer_last;
  // scan downwards so the nearest requester after the previous winner is assigned last
  always_comb begin
    w_win = r_last;
    w_j = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_j = IW'((int'(r_last) + k) % NUM_REQ);
      if (req_valid[w_j]) w_win = w_j;
    end
  end
  assign w_stream = r_state == STREAM;
  // grant is one-hot, so an OR of gated words is the mux
  always_comb begin
    msg_word = '0;
    for (int k = 0; k < NUM_REQ; k++)
      msg_word = msg_word | ((w_stream && r_grant[k]) ? req_word[32*k +: 32] : 32'd0);
  end
  assign msg_valid      = w_stream & |(r_grant & req_word_valid);
  assign msg_last       = w_stream & |(r_grant & req_word_last);
  assign req_word_ready = (w_stream & msg_ready) ? r_grant : '0;
  assign w_xfer_last    = msg_valid & msg_ready & msg_last;
  assign busy           = r_state != IDLE;
  assign req_grant      = r_grant;
  assign req_done       = r_done;
  assign hmac_result    = r_result;
  assign keygen_start   = r_kstart;
  assign hmac_start     = r_hstart;
  assign err_timeout    = r_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last   <= IW'(NUM_REQ - 1);
      r_gidx   <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_kstart <= 1'b0;
      r_hstart <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_kstart <= 1'b0;
      r_hstart <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= '0;
      r_cnt    <= (&r_cnt) ? r_cnt : r_cnt + 32'd1;
      case (r_state)
        IDLE: if (|req_valid) begin
          r_cnt <= '0;
          if (key_valid) begin
            r_gidx  <= w_win;
            r_grant <= NUM_REQ'(1) << w_win;
            r_state <= START;
          end else begin
            r_kstart <= 1'b1;
            r_state  <= KEYGEN;
          end
        end
        KEYGEN: if (key_valid) begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end else if (r_cnt == 32'(KEYGEN_TIMEOUT - 1)) begin
          r_err   <= 1'b1;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        START: begin
          r_hstart <= 1'b1;
          r_cnt    <= '0;
          r_state  <= STREAM;
        end
        STREAM: if (w_xfer_last) begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: if (hmac_done) begin
          r_result <= hmac_value;
          r_cnt    <= '0;
          r_state  <= DONE;
        end else if (r_cnt == 32'(HMAC_TIMEOUT - 1)) begin
          r_err   <= 1'b1;
          r_cnt   <= '0;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= r_grant;
          r_grant <= '0;
          r_last  <= r_gidx;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hmac_request_arbiter.sv
// tb_hmac_request_arbiter: randomized and directed bench for hmac_request_arbiter against a job-level model
module tb_hmac_request_arbiter;
  localparam int NR = 4, KT = 150, HT = 100;
  localparam int P_IDLE = 0, P_KEYGEN = 1, P_START = 2, P_STREAM = 3, P_WAIT = 4, P_DONE = 5;
  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0] req_valid, req_word_valid, req_word_last, req_word_ready, req_grant, req_done;
  logic [32*NR-1:0] req_word;
  logic [511:0] hmac_result, hmac_value;
  logic keygen_start, hmac_start, key_valid, msg_valid, msg_last, msg_ready, hmac_done, busy, err_timeout;
  logic [31:0] msg_word;
  int chk_n = 0, fail_n = 0;
  bit m_valid = 1'b0;
  int m_ph = P_IDLE, m_owner = 0, m_last = NR - 1, m_ent = 0, m_cyc = 0;
  logic [NR-1:0] m_grant = '0, m_done = '0;
  logic m_k = 1'b0, m_h = 1'b0, m_e = 1'b0;
  logic [511:0] m_result = '0;
  int n_k, n_h, n_e, n_d, x_edge, err_edge, s_edge;
  int q_he[$];
  logic [NR-1:0] q_grant[$], q_done[$];
  logic [31:0] q_xw[$];
  logic q_xl[$];
  logic [31:0] w3 [3] = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h00112233};
  logic [511:0] five_a = {16{32'h5A5A5A5A}};

  hmac_request_arbiter #(.NUM_REQ(NR), .KEYGEN_TIMEOUT(KT), .HMAC_TIMEOUT(HT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_word(req_word),
    .req_word_valid(req_word_valid), .req_word_last(req_word_last), .req_word_ready(req_word_ready),
    .req_grant(req_grant), .req_done(req_done), .hmac_result(hmac_result),
    .keygen_start(keygen_start), .hmac_start(hmac_start), .key_valid(key_valid),
    .msg_word(msg_word), .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
    .hmac_done(hmac_done), .hmac_value(hmac_value), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic cmp(string nm, logic [511:0] act, logic [511:0] exp);
    chk_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pick(logic [NR-1:0] rv, int last);
    for (int off = 1; off <= NR; off++)
      if (rv[(last + off) % NR]) return (last + off) % NR;
    return last;
  endfunction

  function automatic logic [NR-1:0] gat(int i);
    return (i < q_grant.size()) ? q_grant[i] : 'x;
  endfunction
  function automatic logic [NR-1:0] dat(int i);
    return (i < q_done.size()) ? q_done[i] : 'x;
  endfunction
  function automatic logic [31:0] xwat(int i);
    return (i < q_xw.size()) ? q_xw[i] : 'x;
  endfunction
  function automatic logic xlat(int i);
    return (i < q_xl.size()) ? q_xl[i] : 1'bx;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // expected outputs for the current cycle, plus logging of what the DUT visibly did
  task automatic check();
    bit str;
    int o;
    if (m_valid) begin
      str = (m_ph == P_STREAM);
      o = m_owner;
      cmp("req_grant", req_grant, m_grant);
      cmp("req_done", req_done, m_done);
      cmp("keygen_start", keygen_start, m_k);
      cmp("hmac_start", hmac_start, m_h);
      cmp("err_timeout", err_timeout, m_e);
      cmp("busy", busy, m_ph != P_IDLE);
      cmp("msg_valid", msg_valid, str && req_word_valid[o]);
      cmp("msg_last", msg_last, str && req_word_last[o]);
      cmp("msg_word", msg_word, str ? req_word[32*o +: 32] : 32'd0);
      cmp("req_word_ready", req_word_ready, (str && msg_ready) ? (NR'(1) << o) : NR'(0));
      cmp("hmac_result", hmac_result, m_result);
    end
    if (keygen_start === 1'b1) n_k++;
    if (hmac_start === 1'b1) begin
      n_h++;
      q_grant.push_back(req_grant);
      q_he.push_back(m_cyc + 1);
    end
    if (err_timeout === 1'b1) begin
      n_e++;
      err_edge = m_cyc;
    end
    if (|req_done === 1'b1) begin
      n_d++;
      q_done.push_back(req_done);
    end
    if ((msg_valid & msg_ready) === 1'b1) begin
      q_xw.push_back(msg_word);
      q_xl.push_back(msg_last);
      x_edge = m_cyc + 1;
    end
  endtask

  // job-level reference: what happens at one rising edge given the sampled inputs
  task automatic model_update();
    m_cyc++;
    m_k = 1'b0;
    m_h = 1'b0;
    m_e = 1'b0;
    m_done = '0;
    if (reset) begin
      m_valid = 1'b1;
      m_ph = P_IDLE;
      m_last = NR - 1;
      m_grant = '0;
      m_result = '0;
    end else begin
      case (m_ph)
        P_IDLE: if (req_valid != 0) begin
          if (key_valid) begin
            m_owner = pick(req_valid, m_last);
            m_grant = NR'(1) << m_owner;
            m_ph = P_START;
          end else begin
            m_k = 1'b1;
            m_ph = P_KEYGEN;
            m_ent = m_cyc;
          end
        end
        P_KEYGEN: if (key_valid) m_ph = P_IDLE;
          else if (m_cyc - m_ent == KT) begin
            m_e = 1'b1;
            m_ph = P_IDLE;
          end
        P_START: begin
          m_h = 1'b1;
          m_ph = P_STREAM;
        end
        P_STREAM: if (req_word_valid[m_owner] && msg_ready && req_word_last[m_owner]) begin
          m_ph = P_WAIT;
          m_ent = m_cyc;
        end
        P_WAIT: if (hmac_done) begin
          m_result = hmac_value;
          m_ph = P_DONE;
        end else if (m_cyc - m_ent == HT) begin
          m_e = 1'b1;
          m_ph = P_DONE;
        end
        P_DONE: begin
          m_done = m_grant;
          m_grant = '0;
          m_last = m_owner;
          m_ph = P_IDLE;
        end
        default: m_ph = P_IDLE;
      endcase
    end
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clr();
    n_k = 0; n_h = 0; n_e = 0; n_d = 0; x_edge = -1; err_edge = -1;
    q_he.delete(); q_grant.delete(); q_done.delete(); q_xw.delete(); q_xl.delete();
  endtask

  task automatic do_reset();
    req_valid = '0; req_word = '0; req_word_valid = '0; req_word_last = '0;
    key_valid = 1'b0; msg_ready = 1'b0; hmac_done = 1'b0; hmac_value = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    do_reset();
    #1;
    cmp("rst_outputs", {req_grant, req_done, req_word_ready, keygen_start, hmac_start,
                        msg_valid, msg_last, msg_word, busy, err_timeout}, 0);
    cmp("rst_result", hmac_result, 0);
    // key missing: one keygen pulse, then a late key leads to grant 0
    clr();
    req_valid = 4'b0001;
    repeat (100) step();
    cmp("t1_keygen_pulses", n_k, 1);
    cmp("t1_no_start_yet", n_h, 0);
    key_valid = 1'b1;
    for (int t = 0; t < 10 && n_h == 0; t++) step();
    step();
    cmp("t1_hstart_pulses", n_h, 1);
    cmp("t1_grant", gat(0), 4'b0001);
    // all four requesting with key ready: rotation 0,1,2,3
    do_reset();
    clr();
    key_valid = 1'b1;
    req_valid = 4'b1111;
    s_edge = m_cyc + 1;
    for (int t = 0; t < 3000 && n_d < 4; t++) begin
      req_word_valid = 4'b1111;
      for (int k = 0; k < NR; k++) begin
        req_word_last[k] = ($urandom_range(0, 2) == 0);
        req_word[32*k +: 32] = $urandom;
      end
      msg_ready = 1'($urandom_range(0, 1));
      hmac_done = ($urandom_range(0, 4) == 0);
      hmac_value = rand512();
      step();
    end
    cmp("t2_start_latency", (q_he.size() > 0) ? q_he[0] - s_edge : -1, 2);
    cmp("t2_done_count", n_d, 4);
    for (int i = 0; i < 4; i++) begin
      cmp("t2_grant_order", gat(i), NR'(1) << i);
      cmp("t2_done_order", dat(i), NR'(1) << i);
    end
    // three words to requester 0 with msg_ready toggling; early hmac_done ignored
    do_reset();
    clr();
    key_valid = 1'b1;
    for (int t = 0; t < 200 && n_d == 0; t++) begin
      req_valid = (n_h == 0) ? 4'b0001 : 4'b0000;
      for (int k = 0; k < NR; k++) req_word[32*k +: 32] = $urandom;
      req_word[31:0] = (q_xw.size() < 3) ? w3[q_xw.size()] : 32'd0;
      req_word_valid = {3'b000, q_xw.size() < 3};
      req_word_last = {3'b000, q_xw.size() == 2};
      msg_ready = ~msg_ready;
      hmac_done = 1'b1;
      hmac_value = (q_xw.size() == 3) ? five_a : rand512();
      step();
    end
    cmp("t3_xfer_count", q_xw.size(), 3);
    for (int i = 0; i < 3; i++) begin
      cmp("t3_word", xwat(i), w3[i]);
      cmp("t3_last", xlat(i), i == 2);
    end
    cmp("t3_result", hmac_result, five_a);
    cmp("t3_done", dat(0), 4'b0001);
    // hmac_done never comes: timeout 100 edges after the last word
    clr();
    hmac_done = 1'b0;
    for (int t = 0; t < 400 && n_d == 0; t++) begin
      req_valid = (n_h == 0) ? 4'b0001 : 4'b0000;
      req_word[31:0] = 32'h13579BDF;
      req_word_valid = {3'b000, q_xw.size() == 0};
      req_word_last = {3'b000, q_xw.size() == 0};
      msg_ready = 1'b1;
      step();
    end
    cmp("t4_timeout_gap", err_edge - x_edge, HT);
    cmp("t4_err_pulses", n_e, 1);
    cmp("t4_done_pulses", n_d, 1);
    cmp("t4_result_kept", hmac_result, five_a);
    // reset in the middle of a stream
    clr();
    for (int t = 0; t < 50 && q_xw.size() < 2; t++) begin
      req_valid = 4'b0010;
      for (int k = 0; k < NR; k++) req_word[32*k +: 32] = $urandom;
      req_word_valid = 4'b0010;
      req_word_last = {2'b00, q_xw.size() == 4, 1'b0};
      msg_ready = 1'b1;
      step();
    end
    cmp("t5_grant", gat(0), 4'b0010);
    cmp("t5_words_before_reset", q_xw.size(), 2);
    msg_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid = '0;
    req_word_valid = '0;
    req_word_last = '0;
    #1;
    cmp("t5_outputs_zero", {req_grant, req_done, req_word_ready, keygen_start, hmac_start,
                            msg_valid, msg_last, msg_word, err_timeout}, 0);
    cmp("t5_busy", busy, 1'b0);
    cmp("t5_result_zero", hmac_result, 0);
    clr();
    req_valid = 4'b1111;
    for (int t = 0; t < 10 && n_h == 0; t++) step();
    cmp("t5_regrant", gat(0), 4'b0001);
    // key never arrives: timeout, then a fresh keygen attempt
    do_reset();
    clr();
    req_valid = 4'b0100;
    repeat (KT + 20) step();
    cmp("t6_err_pulses", n_e, 1);
    cmp("t6_keygen_pulses", n_k, 2);
    // random traffic against the model
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) req_valid = NR'($urandom);
      key_valid = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < NR; k++) begin
        req_word[32*k +: 32] = $urandom;
        req_word_valid[k] = 1'($urandom_range(0, 1));
        req_word_last[k] = ($urandom_range(0, 3) == 0);
      end
      msg_ready = 1'($urandom_range(0, 1));
      hmac_done = ($urandom_range(0, 15) == 0);
      hmac_value = rand512();
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", chk_n, fail_n);
    $finish;
  end
endmodule

// File: doc/hmac_request_arbiter.md
HMAC_REQUEST_ARBITER -- requirements
Module: hmac_request_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the HMAC port, range 2..8.
REQ-002 Parameter KEYGEN_TIMEOUT, default 50000: max cycles waiting for key_valid after keygen_start.
REQ-003 Parameter HMAC_TIMEOUT, default 200000: max cycles waiting for hmac_done after last word.
REQ-004 Clock and reset: clk (rising edge); reset, synchronous, active-high.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 req_valid  in  NUM_REQ  requester i has a pending HMAC job.
REQ-008 req_word  in  32*NUM_REQ  message word of requester i at bits [32i+31:32i].
REQ-009 req_word_valid  in  NUM_REQ  word of requester i valid.
REQ-010 req_word_last  in  NUM_REQ  word of requester i is its final word.
REQ-011 req_word_ready  out  NUM_REQ  word of requester i accepted this cycle.
REQ-012 req_grant  out  NUM_REQ  one-hot grant, held for the whole job.
REQ-013 req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-014 hmac_result  out  512  registered HMAC value of the last successful job.
REQ-015 keygen_start, hmac_start  out  1 each  one-cycle pulses to the key system.
REQ-016 key_valid  in  1  key system reports valid PUF key.
REQ-017 msg_word  out  32; msg_valid, msg_last  out  1; msg_ready  in  1: message stream to the key system.
REQ-018 hmac_done  in  1; hmac_value  in  512: key system completion and result.
REQ-019 busy  out  1  high in any state other than IDLE; err_timeout  out  1  one-cycle timeout pulse.

Function
REQ-020 States: IDLE, KEYGEN, START, STREAM, WAIT, DONE.
REQ-021 IDLE, any req_valid, key_valid=0: pulse keygen_start next cycle, go KEYGEN.
REQ-022 IDLE, any req_valid, key_valid=1: select winner round-robin, starting at index (last_grant+1) mod NUM_REQ; register one-hot req_grant; go START.
REQ-023 KEYGEN: key_valid=1 -> IDLE (arbitration follows next cycle); KEYGEN_TIMEOUT cycles without key_valid -> pulse err_timeout, go IDLE.
REQ-024 START: hmac_start=1 for exactly one cycle, go STREAM.
REQ-025 STREAM: msg_word/msg_valid/msg_last combinationally muxed from the granted requester; req_word_ready[g]=msg_ready; all other ready bits 0.
REQ-026 Word transfer only on msg_valid & msg_ready; transfer with msg_last=1 -> WAIT; no cap on words per job.
REQ-027 WAIT: hmac_done=1 -> latch hmac_value into hmac_result, go DONE; HMAC_TIMEOUT cycles elapsed -> pulse err_timeout, hmac_result unchanged, go DONE.
REQ-028 DONE: req_done[g]=1 one cycle; last_grant <= g; clear req_grant; go IDLE.
REQ-029 hmac_done outside WAIT is ignored.
REQ-030 req_valid deassertion by the granted requester after grant is ignored; job completes.
REQ-031 key_valid is sampled only in IDLE and KEYGEN.
REQ-032 Latency: IDLE with key valid -> hmac_start asserted 2 cycles after req_valid is sampled.
REQ-033 Timeout counters 32-bit, cleared on every state entry; saturate, never wrap.

Reset
REQ-034 reset takes priority over all events, including mid-job: state IDLE, last_grant=NUM_REQ-1 (index 0 wins first), counters 0.
REQ-035 After reset all outputs 0: req_grant, req_done, req_word_ready, keygen_start, hmac_start, msg_valid, msg_last, msg_word, busy, err_timeout, hmac_result.

Verification
REQ-036 key_valid=0, req_valid=4'b0001 -> keygen_start pulse; key_valid raised 100 cycles later -> req_grant=4'b0001, hmac_start pulse.
REQ-037 key_valid=1, req_valid=4'b1111 held across 4 jobs -> grant order 0001,0010,0100,1000; each job ends with exactly one req_done pulse.
REQ-038 Grant 0, 3 words 0xDEADBEEF,0xCAFEBABE,0x00112233 (last on third), msg_ready toggling -> exactly 3 transfers, msg_last on third only; hmac_done with hmac_value=512'h5A..5A -> hmac_result=512'h5A..5A.
REQ-039 hmac_done never arrives, HMAC_TIMEOUT=100 -> err_timeout pulse 100 cycles after last word, req_done pulse, hmac_result unchanged.
REQ-040 Reset asserted in STREAM after 2 of 5 words -> next cycle all outputs 0, busy=0; next request granted to index 0.
